stage_scroller: RTL and testbench
=================================

Name: stage_scroller

Overview:
- Upstream camera/stage controller for the stage builder.
- Produces `stage_posX`, `stage_posY` and `stageCode` from player scroll buttons and a stage-clear request.
- All position and code updates happen only once per frame, in vertical blanking. The downstream pixel lookup therefore sees values that are stable for the whole active video period.
- Each stage world is 32x32 blocks of 32 px (1024x1024 px), viewed through a 640x480 window.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- WORLD_PX, 1024, stage width and height in pixels
- SCROLL_STEP, 2, pixels moved per frame per held button
- NUM_STAGES, 4, number of stages in the ROM; stageCode wraps modulo this
- HOLD_FRAMES, 60, frames frozen between stage clear and next stage load

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst_n  in  1  asynchronous active-low reset
- CounterX  in  32  current pixel column from the video timing generator
- CounterY  in  32  current line from the video timing generator
- start  in  1  level; leaves IDLE
- btn_left  in  1  level; scroll left
- btn_right  in  1  level; scroll right
- btn_up  in  1  level; scroll up
- btn_down  in  1  level; scroll down
- stage_clear  in  1  single-cycle pulse; request the next stage
- stage_posX  out  32  world X offset of screen column 0
- stage_posY  out  32  world Y offset of screen line 0
- stageCode  out  11  active stage index
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking
- transitioning  out  1  high while in HOLD or LOAD

Behaviour:
- Reset (async, rst_n=0):
  - stage_posX=0, stage_posY=0, stageCode=0, frame_tick=0, transitioning=0.
  - State returns to IDLE and the hold counter clears.
  - Applies identically mid-frame and mid-transition.
- frame_tick:
  - Registered; high for exactly one cycle, on the cycle after CounterX==0 && CounterY==V_ACTIVE is sampled.
  - Exactly one pulse per frame. No pulse if the counters never reach that point.
- Derived constants: MAX_X = WORLD_PX-H_ACTIVE = 384; MAX_Y = WORLD_PX-V_ACTIVE = 544.
- Update timing: all output state changes occur on the clock edge ending a frame_tick cycle, so they are visible from the next cycle. The only exception is the transitioning flag on entry to HOLD (see HOLD).
- IDLE state:
  - Positions held at 0.
  - Moves to SCROLL on the first frame_tick with start=1.
- SCROLL state, on each frame_tick:
  - btn_right only: posX = min(posX+SCROLL_STEP, MAX_X).
  - btn_left only: posX = (posX < SCROLL_STEP) ? 0 : posX-SCROLL_STEP.
  - left+right together, or neither: posX unchanged.
  - Y axis behaves the same way with down/up against MAX_Y.
  - X and Y update independently in the same tick (diagonal allowed).
  - Buttons are sampled only on the frame_tick cycle; presses between ticks are ignored.
- SCROLL to HOLD:
  - A stage_clear pulse on any cycle in SCROLL sets an internal pending flag.
  - At the next frame_tick the state moves to HOLD instead of scrolling; positions are frozen that tick.
  - transitioning rises on the cycle after stage_clear (pending flag set).
  - stage_clear coincident with a frame_tick takes effect on that tick; no scroll is applied.
- HOLD state:
  - Counts frame_ticks; on the HOLD_FRAMES-th tick in HOLD, moves to LOAD.
  - Buttons and stage_clear are ignored.
- LOAD state, on the next frame_tick:
  - stageCode = (stageCode+1 == NUM_STAGES) ? 0 : stageCode+1.
  - stage_posX = 0, stage_posY = 0.
  - Clears pending, returns to SCROLL, transitioning falls.
- Width rules:
  - All position arithmetic is 32-bit unsigned. Clamps ensure positions never exceed MAX_X/MAX_Y or underflow.
  - stageCode is 11-bit; its upper bits above log2(NUM_STAGES) stay 0.
- Latency: button change to visible position change is up to one frame plus one cycle.

Test Plan:
- Reset + start: rst_n low, then high; start=1 at the first tick → SCROLL; at the first tick after that, with no buttons, posX=posY=0 and stageCode=0.
- Scroll and clamp: hold btn_right for 200 frames → posX steps 2,4,…, saturates at 384 from frame 192, then stays at 384; btn_left with posX=1 (SCROLL_STEP=2) → posX=0.
- Conflict and diagonal: right+left+down held for 10 frames → posX unchanged, posY=20.
- Stage transition: at posX=100, pulse stage_clear mid-frame → transitioning=1 next cycle; posX stays 100 for 61 ticks; at the 62nd tick stageCode=1, posX=posY=0, transitioning=0.
- Wrap and ignore: stageCode=3 with NUM_STAGES=4, clear → stageCode=0; a second stage_clear pulsed during HOLD causes no extra advance.
- Async reset mid-HOLD: drop rst_n between clock edges → all outputs 0 immediately; after release with start=0, the state stays IDLE across 5 ticks.

Source files
------------

// File: rtl/stage_scroller.sv
// Camera/stage controller: frame-synchronous scroll position and stage sequencing.
// All visible state changes land on the edge that ends the frame_tick cycle.
module stage_scroller #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned WORLD_PX    = 1024,
  parameter int unsigned SCROLL_STEP = 2,
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] CounterX,
  input  logic [31:0] CounterY,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        stage_clear,
  output logic [31:0] stage_posX,
  output logic [31:0] stage_posY,
  output logic [10:0] stageCode,
  output logic        frame_tick,
  output logic        transitioning
);

  localparam logic [31:0] MaxX = 32'(WORLD_PX - H_ACTIVE);
  localparam logic [31:0] MaxY = 32'(WORLD_PX - V_ACTIVE);
  localparam logic [31:0] Step = 32'(SCROLL_STEP);
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StScroll, StHold, StLoad} state_t;

  state_t             state;
  logic               pending;
  logic [HoldW-1:0]   holdCnt;
  logic               hitPrev;
  logic               hit;
  logic [31:0]        nextX;
  logic [31:0]        nextY;
  logic [10:0]        codeInc;

  assign hit     = (CounterX == 32'd0) && (CounterY == 32'(V_ACTIVE));
  assign codeInc = stageCode + 11'd1;

  always_comb begin
    nextX = stage_posX;
    if (btn_right && !btn_left) begin
      nextX = (stage_posX + Step > MaxX) ? MaxX : stage_posX + Step;
    end else if (btn_left && !btn_right) begin
      nextX = (stage_posX < Step) ? 32'd0 : stage_posX - Step;
    end
  end

  always_comb begin
    nextY = stage_posY;
    if (btn_down && !btn_up) begin
      nextY = (stage_posY + Step > MaxY) ? MaxY : stage_posY + Step;
    end else if (btn_up && !btn_down) begin
      nextY = (stage_posY < Step) ? 32'd0 : stage_posY - Step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      pending       <= 1'b0;
      holdCnt       <= '0;
      hitPrev       <= 1'b0;
      frame_tick    <= 1'b0;
      stage_posX    <= 32'd0;
      stage_posY    <= 32'd0;
      stageCode     <= 11'd0;
      transitioning <= 1'b0;
    end else begin
      // Rising-edge guard keeps the pulse to one per frame even if the counters dwell.
      hitPrev    <= hit;
      frame_tick <= hit && !hitPrev;
      case (state)
        StIdle: begin
          if (frame_tick && start) state <= StScroll;
        end
        StScroll: begin
          if (frame_tick) begin
            if (pending || stage_clear) begin
              state         <= StHold;
              holdCnt       <= '0;
              pending       <= 1'b1;
              transitioning <= 1'b1;
            end else begin
              stage_posX <= nextX;
              stage_posY <= nextY;
            end
          end else if (stage_clear) begin
            pending       <= 1'b1;
            transitioning <= 1'b1;
          end
        end
        StHold: begin
          if (frame_tick) begin
            if (holdCnt == HoldW'(HOLD_FRAMES - 1)) state <= StLoad;
            else holdCnt <= holdCnt + 1'b1;
          end
        end
        StLoad: begin
          if (frame_tick) begin
            stageCode     <= (codeInc == 11'(NUM_STAGES)) ? 11'd0 : codeInc;
            stage_posX    <= 32'd0;
            stage_posY    <= 32'd0;
            pending       <= 1'b0;
            transitioning <= 1'b0;
            state         <= StScroll;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_scroller.sv
// Directed self-checking bench for stage_scroller; counters are driven directly for short frames.
module tb_stage_scroller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] CounterX = 32'd5;
  logic [31:0] CounterY = 32'd0;
  logic        start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        stage_clear = 1'b0;
  logic [31:0] stage_posX;
  logic [31:0] stage_posY;
  logic [10:0] stageCode;
  logic        frame_tick;
  logic        transitioning;

  integer assertions = 0;
  integer failures = 0;

  always #5 clk = ~clk;

  stage_scroller dut (
    .clk(clk), .rst_n(rst_n), .CounterX(CounterX), .CounterY(CounterY), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .stage_clear(stage_clear), .stage_posX(stage_posX), .stage_posY(stage_posY),
    .stageCode(stageCode), .frame_tick(frame_tick), .transitioning(transitioning)
  );

  // One frame: blanking point for a cycle, tick cycle, then outputs are settled.
  task automatic tick;
    @(negedge clk); CounterX = 32'd0; CounterY = 32'd480;
    @(negedge clk); CounterX = 32'd8; CounterY = 32'd0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clear;
    @(negedge clk); stage_clear = 1'b1;
    @(negedge clk); stage_clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    assertions++;
    if (stage_posX !== 32'd0 || stage_posY !== 32'd0 || stageCode !== 11'd0 ||
        frame_tick !== 1'b0 || transitioning !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: x=%0d y=%0d code=%0d ft=%b tr=%b, required all 0",
               stage_posX, stage_posY, stageCode, frame_tick, transitioning);
    end
    @(negedge clk); rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    assertions++;
    if (stage_posX !== 32'd0 || stage_posY !== 32'd0 || stageCode !== 11'd0) begin
      failures++;
      $display("FAIL reset_start: x=%0d y=%0d code=%0d, required 0 0 0",
               stage_posX, stage_posY, stageCode);
    end
  endtask

  task automatic test_frame_tick;
    @(negedge clk); CounterX = 32'd0; CounterY = 32'd480;
    @(negedge clk); CounterX = 32'd1;
    assertions++;
    if (frame_tick !== 1'b1) begin
      failures++; $display("FAIL tick_high: got %b required 1", frame_tick);
    end
    @(negedge clk);
    assertions++;
    if (frame_tick !== 1'b0) begin
      failures++; $display("FAIL tick_width: got %b required 0", frame_tick);
    end
    // Counters near but not at the blanking point must not tick.
    CounterX = 32'd0; CounterY = 32'd479;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      CounterX = 32'd1; CounterY = 32'd480;
      assertions++;
      if (frame_tick !== 1'b0) begin
        failures++; $display("FAIL tick_spurious: cycle %0d got %b required 0", i, frame_tick);
      end
    end
    CounterX = 32'd8; CounterY = 32'd0;
  endtask

  task automatic test_scroll_clamp;
    int unsigned exp;
    btn_right = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      exp = (2 * k > 384) ? 384 : 2 * k;
      assertions++;
      if (stage_posX !== exp) begin
        failures++; $display("FAIL right_clamp: frame %0d got %0d required %0d", k, stage_posX, exp);
      end
    end
    btn_right = 1'b0; btn_left = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      exp = (2 * k > 384) ? 0 : 384 - 2 * k;
      assertions++;
      if (stage_posX !== exp) begin
        failures++; $display("FAIL left_clamp: frame %0d got %0d required %0d", k, stage_posX, exp);
      end
    end
    btn_left = 1'b0;
    // A mid-frame press with no tick must not move the window.
    @(negedge clk); btn_right = 1'b1;
    repeat (4) @(negedge clk);
    btn_right = 1'b0;
    tick();
    assertions++;
    if (stage_posX !== 32'd0 || stage_posY !== 32'd0) begin
      failures++; $display("FAIL between_ticks: x=%0d y=%0d required 0 0", stage_posX, stage_posY);
    end
  endtask

  task automatic test_conflict_diagonal;
    btn_right = 1'b1; ticks(5); btn_right = 1'b0;
    btn_right = 1'b1; btn_left = 1'b1; btn_down = 1'b1;
    ticks(10);
    assertions++;
    if (stage_posX !== 32'd10 || stage_posY !== 32'd20) begin
      failures++; $display("FAIL conflict: x=%0d y=%0d required 10 20", stage_posX, stage_posY);
    end
    btn_right = 1'b0; btn_up = 1'b1;
    tick();
    assertions++;
    if (stage_posX !== 32'd8 || stage_posY !== 32'd20) begin
      failures++; $display("FAIL diag_conflict: x=%0d y=%0d required 8 20", stage_posX, stage_posY);
    end
    btn_left = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  // Runs one full clear from a mid-frame pulse; optional extra pulse during HOLD.
  task automatic run_transition(input logic extraClear, input logic [31:0] holdX,
                                input logic [10:0] expCode);
    tick();
    pulse_clear();
    assertions++;
    if (transitioning !== 1'b1) begin
      failures++; $display("FAIL trans_rise: got %b required 1", transitioning);
    end
    btn_right = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (extraClear && k == 10) pulse_clear();
      if (k == 1 || k == 30 || k == 61) begin
        assertions++;
        if (stage_posX !== holdX || transitioning !== 1'b1) begin
          failures++;
          $display("FAIL hold_freeze: tick %0d x=%0d tr=%b required x=%0d tr=1",
                   k, stage_posX, transitioning, holdX);
        end
      end
    end
    btn_right = 1'b0;
    tick();
    assertions++;
    if (stageCode !== expCode || stage_posX !== 32'd0 || stage_posY !== 32'd0 ||
        transitioning !== 1'b0) begin
      failures++;
      $display("FAIL load: code=%0d x=%0d y=%0d tr=%b required code=%0d 0 0 0",
               stageCode, stage_posX, stage_posY, transitioning, expCode);
    end
  endtask

  task automatic test_transition;
    btn_right = 1'b1; ticks(46); btn_right = 1'b0;
    assertions++;
    if (stage_posX !== 32'd100) begin
      failures++; $display("FAIL setup_x: got %0d required 100", stage_posX);
    end
    run_transition(1'b0, 32'd100, 11'd1);
  endtask

  task automatic test_wrap_ignore;
    run_transition(1'b0, 32'd0, 11'd2);
    run_transition(1'b0, 32'd0, 11'd3);
    run_transition(1'b1, 32'd0, 11'd0);
    ticks(3);
    assertions++;
    if (stageCode !== 11'd0 || transitioning !== 1'b0) begin
      failures++;
      $display("FAIL extra_clear: code=%0d tr=%b required 0 0", stageCode, transitioning);
    end
  endtask

  task automatic test_back_to_back;
    // Clear coincident with the tick: no scroll applied, straight into HOLD.
    btn_right = 1'b1;
    @(negedge clk); CounterX = 32'd0; CounterY = 32'd480;
    @(negedge clk); CounterX = 32'd8; CounterY = 32'd0; stage_clear = 1'b1;
    @(negedge clk); stage_clear = 1'b0;
    assertions++;
    if (stage_posX !== 32'd0 || transitioning !== 1'b1) begin
      failures++;
      $display("FAIL coincident: x=%0d tr=%b required 0 1", stage_posX, transitioning);
    end
    ticks(60);
    btn_right = 1'b0;
    assertions++;
    if (stageCode !== 11'd0) begin
      failures++; $display("FAIL coin_hold: code=%0d required 0", stageCode);
    end
    tick();
    assertions++;
    if (stageCode !== 11'd1 || transitioning !== 1'b0) begin
      failures++;
      $display("FAIL coin_load: code=%0d tr=%b required 1 0", stageCode, transitioning);
    end
  endtask

  task automatic test_async_reset;
    btn_right = 1'b1; ticks(3); btn_right = 1'b0;
    pulse_clear();
    ticks(5);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    assertions++;
    if (stage_posX !== 32'd0 || stage_posY !== 32'd0 || stageCode !== 11'd0 ||
        frame_tick !== 1'b0 || transitioning !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: x=%0d y=%0d code=%0d ft=%b tr=%b required all 0",
               stage_posX, stage_posY, stageCode, frame_tick, transitioning);
    end
    @(negedge clk); rst_n = 1'b1;
    start = 1'b0; btn_right = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      assertions++;
      if (stage_posX !== 32'd0 || transitioning !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold: tick %0d x=%0d tr=%b required 0 0", k, stage_posX, transitioning);
      end
    end
    btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_scroll_clamp();
    test_conflict_diagonal();
    test_transition();
    test_wrap_ignore();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
